// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and bus widths for the memory-port arbiter.
// Holds the state and grant encodings used by the arbiter and its round-robin picker.
package mem_port_arbiter_pkg;

  localparam int unsigned DataAddrBus  = 32;
  localparam int unsigned CacheLineBus = 128;
  localparam int unsigned WlenBus      = 4;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbBusyI = 2'd1,
    ArbBusyD = 2'd2
  } arb_state_e;

  localparam logic GntI = 1'b0;
  localparam logic GntD = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin picker between the ifetch and data requesters.
// On a tie the requester that was not granted last wins.
module mem_arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic last_gnt_i,
  output logic gnt_o
);

  always_comb begin
    if (req_i_i && req_d_i) begin
      gnt_o = ~last_gnt_i;
    end else if (req_d_i) begin
      gnt_o = GntD;
    end else begin
      gnt_o = GntI;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the memory bus between ifetch refill and the data port.
// Optional watchdog abort of a stalled transaction is built with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DataAddrBus,
  parameter int unsigned LINE_W      = CacheLineBus,
  parameter int unsigned WLEN_W      = WlenBus,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr_in,
  input  logic              i_rdata_en_in,
  output logic [LINE_W-1:0] i_rdata_out,
  output logic              i_rdata_valid_out,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic              d_rdata_en_in,
  input  logic              d_wdata_en_in,
  input  logic [LINE_W-1:0] d_wdata_in,
  input  logic [WLEN_W-1:0] d_wlen_in,
  output logic              d_wdata_ready_out,
  output logic [LINE_W-1:0] d_rdata_out,
  output logic              d_rdata_valid_out,
  output logic [ADDR_W-1:0] data_addr_out,
  output logic              rdata_en_out,
  output logic              wdata_en_out,
  output logic [LINE_W-1:0] wdata_out,
  output logic [WLEN_W-1:0] wlen_out,
  input  logic              wdata_ready_in,
  input  logic [LINE_W-1:0] rdata_in,
  input  logic              rdata_valid_in,
  output logic              bus_err_out
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [WLEN_W-1:0] wlen_q, wlen_d;

  logic req_i, req_d, pick_gnt;
  logic done, launch, launch_gnt;

  assign req_i = i_rdata_en_in;
  assign req_d = d_rdata_en_in | d_wdata_en_in;

  mem_arb_rr_pick u_pick (
    .req_i_i    (req_i),
    .req_d_i    (req_d),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick_gnt)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d           = state_q;
    last_gnt_d        = last_gnt_q;
    addr_d            = addr_q;
    rd_en_d           = rd_en_q;
    wr_en_d           = wr_en_q;
    wdata_d           = wdata_q;
    wlen_d            = wlen_q;
    i_rdata_out       = '0;
    i_rdata_valid_out = 1'b0;
    d_rdata_out       = '0;
    d_rdata_valid_out = 1'b0;
    d_wdata_ready_out = 1'b0;
    bus_err_out       = 1'b0;
    done              = 1'b0;
    launch            = 1'b0;
    launch_gnt        = pick_gnt;

    unique case (state_q)
      ArbIdle: launch = req_i | req_d;
      ArbBusyI: begin
        if (rdata_valid_in) begin
          done              = 1'b1;
          i_rdata_out       = rdata_in;
          i_rdata_valid_out = i_rdata_en_in;
          launch            = req_d;
          launch_gnt        = GntD;
        end
      end
      ArbBusyD: begin
        if (wr_en_q ? wdata_ready_in : rdata_valid_in) begin
          done = 1'b1;
          if (wr_en_q) begin
            d_wdata_ready_out = d_wdata_en_in;
          end else begin
            d_rdata_out       = rdata_in;
            // A read is only still wanted if the port has not switched to a write.
            d_rdata_valid_out = d_rdata_en_in & ~d_wdata_en_in;
          end
          launch     = req_i;
          launch_gnt = GntI;
        end
      end
      default: state_d = ArbIdle;
    endcase

    if (done) begin
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
      state_d = ArbIdle;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    if (state_q != ArbIdle && !done && cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
      bus_err_out = 1'b1;
      if (state_q == ArbBusyI) begin
        i_rdata_valid_out = 1'b1;
      end else if (wr_en_q) begin
        d_wdata_ready_out = 1'b1;
      end else begin
        d_rdata_valid_out = 1'b1;
      end
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
      state_d = ArbIdle;
    end
`endif

    if (launch) begin
      last_gnt_d = launch_gnt;
      if (launch_gnt == GntD) begin
        state_d = ArbBusyD;
        addr_d  = d_addr_in;
        // Read and write together is illegal; the write takes priority.
        wr_en_d = d_wdata_en_in;
        rd_en_d = ~d_wdata_en_in;
        wdata_d = d_wdata_en_in ? d_wdata_in : '0;
        wlen_d  = d_wdata_en_in ? d_wlen_in : '0;
      end else begin
        state_d = ArbBusyI;
        addr_d  = i_addr_in;
        rd_en_d = 1'b1;
        wr_en_d = 1'b0;
        wdata_d = '0;
        wlen_d  = '0;
      end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    if (launch || state_q == ArbIdle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ArbIdle;
      last_gnt_q <= GntI;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      wlen_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      wlen_q     <= wlen_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign data_addr_out = addr_q;
  assign rdata_en_out  = rd_en_q;
  assign wdata_en_out  = wr_en_q;
  assign wdata_out     = wdata_q;
  assign wlen_out      = wlen_q;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
    !(d_rdata_en_in && d_wdata_en_in));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory-side bus between the instruction-fetch refill port (read-only) and the data port (cached_mem memory-side outputs).
- Grants one requester at a time, round-robin. Latches the granted request into registers and holds it on the memory bus until the matching completion arrives.
- Sits between the core's two memory-side masters and the memory/interconnect.

Parameters:
ADDR_W, 32, address width (matches DATA_ADDR_BUS)
LINE_W, 128, cache-line data width (matches CACHE_LINE_BUS)
WLEN_W, 4, write-length width (matches WLEN_BUS)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_addr_in  in  ADDR_W  ifetch request address
i_rdata_en_in  in  1  ifetch read request, level, held until i_rdata_valid_out
i_rdata_out  out  LINE_W  ifetch read data
i_rdata_valid_out  out  1  ifetch read-done pulse
d_addr_in  in  ADDR_W  data request address
d_rdata_en_in  in  1  data read request, level
d_wdata_en_in  in  1  data write request, level
d_wdata_in  in  LINE_W  data write payload
d_wlen_in  in  WLEN_W  data write length
d_wdata_ready_out  out  1  data write-done pulse
d_rdata_out  out  LINE_W  data read data
d_rdata_valid_out  out  1  data read-done pulse
data_addr_out  out  ADDR_W  memory address (registered)
rdata_en_out  out  1  memory read enable (registered)
wdata_en_out  out  1  memory write enable (registered)
wdata_out  out  LINE_W  memory write data (registered)
wlen_out  out  WLEN_W  memory write length (registered)
wdata_ready_in  in  1  memory write complete
rdata_in  in  LINE_W  memory read data
rdata_valid_in  in  1  memory read complete
bus_err_out  out  1  watchdog abort pulse (tied 0 without the optional feature)

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Register last_gnt (0=I, 1=D).
- Reset: state=IDLE, last_gnt=I, so D wins the first tie. All memory outputs 0. All requester outputs 0.
- IDLE:
  - Sample requests: req_i=i_rdata_en_in; req_d=d_rdata_en_in|d_wdata_en_in.
  - Only one request: grant it. Both: grant the one that is not last_gnt.
  - On grant, next edge: latch addr, op, wdata and wlen (wdata/wlen only for D write) into the output registers, set last_gnt, and enter BUSY_x.
  - Memory request is visible 1 cycle after the request is first seen.
- D read+write asserted together is illegal. Write wins and an assertion fires.
- BUSY_x: memory outputs hold their latched values. Completion is rdata_valid_in for a read or wdata_ready_in for a write. A completion of the other type is ignored.
- On the completion cycle:
  - rdata_in is forwarded combinationally to x_rdata_out.
  - x_*_valid/ready_out is pulsed for that cycle only if requester x still asserts the same op. Otherwise the response is discarded (e.g. an ifetch flush).
  - Memory enables clear on the next edge.
  - If the other requester is pending in that cycle, go directly to its BUSY state, latching its request (back-to-back, no bubble). Otherwise go to IDLE.
- The non-granted requester always sees valid/ready=0. x_rdata_out=0 when not completing.
- A requester dropping its request mid-transaction does not abort the memory transaction.
- rst asserted mid-transaction: immediate return to reset state, no response pulse. Memory must tolerate the dropped enable.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Enabled: a counter clears on entry to BUSY_x and increments each BUSY cycle. At TIMEOUT_CYC-1 without completion:
  - pulse bus_err_out for one cycle;
  - pulse the granted requester's valid/ready with rdata_out=0;
  - clear the memory enables and return to IDLE.
- Disabled: no counter, bus_err_out=0, BUSY waits indefinitely.

Decomposition:
- Shared package/params.v holds: state encodings (ARB_IDLE/ARB_BUSY_I/ARB_BUSY_D), grant encodings (GNT_I/GNT_D), and the existing bus width macros.
- One natural sub-module: mem_arb_rr_pick. It is a combinational 2-way round-robin picker: (req_i, req_d, last_gnt) -> gnt.

Test Plan:
- Reset, then d_rdata_en_in=1 @0x100 -> rdata_en_out=1, data_addr_out=0x100 one cycle later. rdata_valid_in with 0xAB.. -> d_rdata_valid_out=1 that cycle and d_rdata_out=0xAB.. ; i outputs stay 0.
- Both request in the same cycle after reset -> D granted first. On D completion, I is granted with no IDLE cycle. Next tie -> D (alternation).
- D write 0x200, wlen=3, data 0x55.. -> wdata_en_out=1 with latched values; d_wdata_ready_out pulses on wdata_ready_in. A stray rdata_valid_in during the write is ignored.
- Ifetch read 0x300, then i_rdata_en_in drops mid-flight -> rdata_en_out stays 1 until rdata_valid_in, and i_rdata_valid_out is never asserted.
- rst asserted in BUSY_D -> next cycle all outputs 0, state IDLE, and the next tie grants D.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, no memory response -> bus_err_out and d_rdata_valid_out pulse 8 cycles after grant, rdata_en_out clears, arbiter returns to IDLE.
